// File: rtl/posit_conv_sched.sv
// Two-requester scheduler in front of one shared posit(8) -> Q5.10 sign-magnitude converter.
// Define POSIT_SCHED_FIXED_PRIO_EN for fixed A-first priority instead of round-robin.
`timescale 1ns/1ps
module posit_conv_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic [7:0]  a_posit1,
   input  logic [7:0]  a_posit2,
   output logic        a_ack,
   input  logic        b_req,
   input  logic [7:0]  b_posit1,
   input  logic [7:0]  b_posit2,
   output logic        b_ack,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_id,
   output logic [15:0] out_bin1,
   output logic [15:0] out_bin2,
   output logic [1:0]  out_sat,
   output logic [1:0]  out_nar,
   output logic        busy
);

   // Handshakes: a requester holds req and operands until its one-cycle ack, which only
   // occurs in IDLE; operands are captured on that edge. A result transfers on a cycle
   // with out_valid && out_ready and holds unchanged until then.
   typedef enum logic [1:0] {IDLE, CONV1, CONV2, RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        grant_b;
   logic [7:0]  op1;
   logic [7:0]  op2;

   logic [7:0]  cv_in;
   logic [3:0]  cv_shamt;
   logic [18:0] cv_mag;
   logic [15:0] cv_bin;
   logic        cv_sat;
   logic        cv_nar;

`ifdef POSIT_SCHED_FIXED_PRIO_EN
   assign grant_b = ~a_req;
`else
   logic last_b;

   assign grant_b = b_req & (~a_req | ~last_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b <= 1'b1;
      end else if (accept) begin
         last_b <= grant_b;
      end
   end
`endif

   // rst_n gates accept so the acks are low while reset is held
   assign accept    = rst_n & (state == IDLE) & (a_req | b_req);
   assign a_ack     = accept & ~grant_b;
   assign b_ack     = accept & grant_b;
   assign out_valid = (state == RESP);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (accept) state_nxt = CONV1;
         CONV1: state_nxt = CONV2;
         CONV2: state_nxt = RESP;
         RESP:  if (out_ready) state_nxt = IDLE;
      endcase
   end

   // Shared converter: operand 1 during CONV1, operand 2 during CONV2
   always_comb begin
      cv_in    = (state == CONV2) ? op2 : op1;
      cv_shamt = {1'b0, cv_in[6:4]} + 4'd6;
      cv_mag   = {14'd0, 1'b1, cv_in[3:0]} << cv_shamt;
      cv_sat   = 1'b0;
      cv_nar   = 1'b0;
      cv_bin   = 16'h0000;
      if (cv_in[6:0] == 7'd0) begin
         cv_nar = cv_in[7];
         cv_bin = {cv_in[7], 15'd0};
      end else begin
         cv_sat = |cv_mag[18:15];
         cv_bin = {cv_in[7], cv_sat ? 15'h7FFF : cv_mag[14:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op1      <= 8'h00;
         op2      <= 8'h00;
         out_id   <= 1'b0;
         out_bin1 <= 16'h0000;
         out_bin2 <= 16'h0000;
         out_sat  <= 2'b00;
         out_nar  <= 2'b00;
      end else begin
         if (accept) begin
            op1    <= grant_b ? b_posit1 : a_posit1;
            op2    <= grant_b ? b_posit2 : a_posit2;
            out_id <= grant_b;
         end
         if (state == CONV1) begin
            out_bin1   <= cv_bin;
            out_sat[0] <= cv_sat;
            out_nar[0] <= cv_nar;
         end
         if (state == CONV2) begin
            out_bin2   <= cv_bin;
            out_sat[1] <= cv_sat;
            out_nar[1] <= cv_nar;
         end
      end
   end

endmodule
